plot_move_sequencer: RTL and testbench

- Accepts relative pen-plotter move commands over a valid/ready handshake.
- Sequences each move in two phases:
  - pen raise/lower with a servo settle wait;
  - a rate-limited Bresenham line, issued as per-axis step pulses and directions.
- Owns the absolute X/Y position counters.
- Sits between the processor-facing register interface and the stepper/servo drivers, replacing direct level-driven move flags.

---
 rtl/plot_move_sequencer_pkg.sv | 22 ++
 rtl/plot_move_sequencer_if.sv | 30 +++
 rtl/plot_move_sequencer_step_rate_timer.sv | 31 +++
 rtl/plot_move_sequencer.sv | 201 ++++++++++++++++++++
 tb/tb_plot_move_sequencer.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/plot_move_sequencer_pkg.sv
// Shared constants for the pen-plotter move sequencer and its drivers.
package plot_move_sequencer_pkg;

  // Sequencer state encodings
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PEN  = 2'd1;
  localparam logic [1:0] ST_STEP = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // Direction encodings driven on dir_x / dir_y
  localparam logic DIR_POS = 1'b0;
  localparam logic DIR_NEG = 1'b1;

  // Default timing (100 MHz clock): 1 kHz step rate, 250 ms servo settle
  localparam int unsigned DEF_STEP_DIV   = 100000;
  localparam int unsigned DEF_PEN_SETTLE = 25000000;

  // Default datapath widths
  localparam int unsigned DEF_DELTA_W = 16;
  localparam int unsigned DEF_POS_W   = 32;

endpackage

// File: rtl/plot_move_sequencer_if.sv
// Move-command handshake between the register front end and the sequencer.
interface plot_move_sequencer_if
  import plot_move_sequencer_pkg::*;
#(
  parameter int unsigned DELTA_W = DEF_DELTA_W
);

  logic               cmd_valid;
  logic               cmd_ready;
  logic [DELTA_W-1:0] cmd_dx;
  logic [DELTA_W-1:0] cmd_dy;
  logic               cmd_pen;

  modport master (
    output cmd_valid,
    output cmd_dx,
    output cmd_dy,
    output cmd_pen,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_dx,
    input  cmd_dy,
    input  cmd_pen,
    output cmd_ready
  );

endinterface

// File: rtl/plot_move_sequencer_step_rate_timer.sv
// Divider emitting a one-cycle tick every DIV enabled cycles; restarts on clear.
module step_rate_timer
  import plot_move_sequencer_pkg::*;
#(
  parameter int unsigned DIV = DEF_STEP_DIV
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick_c
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q;

  // Tick is combinational so the consumer acts on the DIV-th enabled cycle
  assign tick_c = enable && (cnt_q == CNT_LAST);

  // Enabled-cycle counter wrapping at DIV-1
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      cnt_q <= '0;
    end else if (enable) begin
      cnt_q <= (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/plot_move_sequencer.sv
// Pen-plotter move sequencer: pen settle, then rate-limited Bresenham stepping.
module plot_move_sequencer
  import plot_move_sequencer_pkg::*;
#(
  parameter int unsigned STEP_DIV   = DEF_STEP_DIV,
  parameter int unsigned PEN_SETTLE = DEF_PEN_SETTLE,
  parameter int unsigned DELTA_W    = DEF_DELTA_W,
  parameter int unsigned POS_W      = DEF_POS_W
) (
  input  logic                    clock,
  input  logic                    reset,
  plot_move_sequencer_if.slave    cmd,
  input  logic                    home,
  input  logic                    abort,
  output logic                    step_x,
  output logic                    dir_x,
  output logic                    step_y,
  output logic                    dir_y,
  output logic                    pen_down,
  output logic                    busy,
  output logic                    done,
  output logic signed [POS_W-1:0] cur_x,
  output logic signed [POS_W-1:0] cur_y
);

  // One extra bit so err + minor never overflows before the compare
  localparam int unsigned ERR_W = DELTA_W + 1;

  logic [1:0]         state_q;
  logic [1:0]         state_d;
  logic               ready_q;

  logic               accept_c;
  logic [DELTA_W-1:0] mag_x_c;
  logic [DELTA_W-1:0] mag_y_c;
  logic               x_major_c;
  logic [DELTA_W-1:0] major_c;
  logic [DELTA_W-1:0] minor_c;

  logic               x_major_q;
  logic [DELTA_W-1:0] major_q;
  logic [DELTA_W-1:0] minor_q;
  logic [DELTA_W-1:0] remain_q;
  logic [DELTA_W-1:0] remain_d;
  logic [ERR_W-1:0]   err_q;
  logic [ERR_W-1:0]   err_d;
  logic [ERR_W-1:0]   err_sum_c;
  logic               minor_hit_c;

  logic               step_x_d;
  logic               step_y_d;
  logic               settle_tick_c;
  logic               step_tick_c;

  assign cmd.cmd_ready = ready_q;

  // Handshake and command magnitude decode (most-negative delta maps to 2^(DELTA_W-1))
  assign accept_c  = cmd.cmd_valid && (state_q == ST_IDLE);
  assign mag_x_c   = cmd.cmd_dx[DELTA_W-1] ? (~cmd.cmd_dx + DELTA_W'(1)) : cmd.cmd_dx;
  assign mag_y_c   = cmd.cmd_dy[DELTA_W-1] ? (~cmd.cmd_dy + DELTA_W'(1)) : cmd.cmd_dy;
  assign x_major_c = (mag_x_c >= mag_y_c);
  assign major_c   = x_major_c ? mag_x_c : mag_y_c;
  assign minor_c   = x_major_c ? mag_y_c : mag_x_c;

  // Bresenham error accumulate and minor-axis decision
  assign err_sum_c   = err_q + ERR_W'(minor_q);
  assign minor_hit_c = (err_sum_c >= ERR_W'(major_q));

  // Servo settle count, running only while in PEN
  step_rate_timer #(
    .DIV (PEN_SETTLE)
  ) u_settle_timer (
    .clock  (clock),
    .reset  (reset),
    .clear  (state_q != ST_PEN),
    .enable (state_q == ST_PEN),
    .tick_c (settle_tick_c)
  );

  // Major-axis step rate, restarted on every entry to STEP
  step_rate_timer #(
    .DIV (STEP_DIV)
  ) u_step_timer (
    .clock  (clock),
    .reset  (reset),
    .clear  (state_q != ST_STEP),
    .enable (state_q == ST_STEP),
    .tick_c (step_tick_c)
  );

  // Next-state, step decisions and Bresenham datapath update
  always_comb begin
    state_d  = state_q;
    step_x_d = 1'b0;
    step_y_d = 1'b0;
    err_d    = err_q;
    remain_d = remain_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          err_d    = ERR_W'(major_c >> 1);
          remain_d = major_c;
          state_d  = (cmd.cmd_pen != pen_down) ? ST_PEN : ST_STEP;
        end
      end
      ST_PEN: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (settle_tick_c) begin
          state_d = ST_STEP;
        end
      end
      ST_STEP: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (remain_q == '0) begin
          state_d = ST_DONE;
        end else if (step_tick_c) begin
          step_x_d = x_major_q;
          step_y_d = !x_major_q;
          if (minor_hit_c) begin
            if (x_major_q) begin
              step_y_d = 1'b1;
            end else begin
              step_x_d = 1'b1;
            end
            err_d = err_sum_c - ERR_W'(major_q);
          end else begin
            err_d = err_sum_c;
          end
          remain_d = remain_q - DELTA_W'(1);
          if (remain_q == DELTA_W'(1)) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, registered status/pulse outputs and per-command latches
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      ready_q   <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      step_x    <= 1'b0;
      step_y    <= 1'b0;
      dir_x     <= DIR_POS;
      dir_y     <= DIR_POS;
      pen_down  <= 1'b0;
      x_major_q <= 1'b1;
      major_q   <= '0;
      minor_q   <= '0;
      remain_q  <= '0;
      err_q     <= '0;
    end else begin
      state_q  <= state_d;
      ready_q  <= (state_d == ST_IDLE);
      busy     <= (state_d != ST_IDLE);
      done     <= (state_d == ST_DONE);
      step_x   <= step_x_d;
      step_y   <= step_y_d;
      remain_q <= remain_d;
      err_q    <= err_d;
      if (accept_c) begin
        dir_x     <= cmd.cmd_dx[DELTA_W-1] ? DIR_NEG : DIR_POS;
        dir_y     <= cmd.cmd_dy[DELTA_W-1] ? DIR_NEG : DIR_POS;
        pen_down  <= cmd.cmd_pen;
        x_major_q <= x_major_c;
        major_q   <= major_c;
        minor_q   <= minor_c;
      end
    end
  end

  // Absolute position: home in IDLE, otherwise follow issued step pulses
  always_ff @(posedge clock) begin
    if (reset) begin
      cur_x <= '0;
      cur_y <= '0;
    end else if (home && (state_q == ST_IDLE)) begin
      cur_x <= '0;
      cur_y <= '0;
    end else begin
      if (step_x) begin
        cur_x <= (dir_x == DIR_NEG) ? cur_x - POS_W'(1) : cur_x + POS_W'(1);
      end
      if (step_y) begin
        cur_y <= (dir_y == DIR_NEG) ? cur_y - POS_W'(1) : cur_y + POS_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_plot_move_sequencer.sv
// Bench for plot_move_sequencer: directed plan plus random moves vs a closed-form model.
module tb_plot_move_sequencer;

  localparam int unsigned STEP_DIV   = 4;
  localparam int unsigned PEN_SETTLE = 10;
  localparam int unsigned DELTA_W    = 16;
  localparam int unsigned POS_W      = 32;

  logic                    clock;
  logic                    reset;
  logic                    home;
  logic                    abort;
  logic                    step_x;
  logic                    dir_x;
  logic                    step_y;
  logic                    dir_y;
  logic                    pen_down;
  logic                    busy;
  logic                    done;
  logic signed [POS_W-1:0] cur_x;
  logic signed [POS_W-1:0] cur_y;

  int   n_cmp;
  int   n_bad;
  int   exp_x;
  int   exp_y;
  logic exp_pen;

  plot_move_sequencer_if #(.DELTA_W(DELTA_W)) cmd_if ();

  plot_move_sequencer #(
    .STEP_DIV   (STEP_DIV),
    .PEN_SETTLE (PEN_SETTLE),
    .DELTA_W    (DELTA_W),
    .POS_W      (POS_W)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .cmd      (cmd_if),
    .home     (home),
    .abort    (abort),
    .step_x   (step_x),
    .dir_x    (dir_x),
    .step_y   (step_y),
    .dir_y    (dir_y),
    .pen_down (pen_down),
    .busy     (busy),
    .done     (done),
    .cur_x    (cur_x),
    .cur_y    (cur_y)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // {step_x, step_y, done} expected c cycles after accept; base = cycle STEP is entered.
  // Minor steps up to tick i follow floor((major/2 + i*minor) / major).
  function automatic logic [2:0] exp_pulses(input int c, input int base, input int mj,
                                            input int mn, input bit xmaj);
    logic maj;
    logic mnr;
    logic dn;
    int   i;
    maj = 1'b0;
    mnr = 1'b0;
    dn  = 1'b0;
    if (mj == 0) begin
      dn = (c == base + 1);
    end else begin
      if (c > base && ((c - base) % int'(STEP_DIV)) == 0) begin
        i = (c - base) / int'(STEP_DIV);
        if (i <= mj) begin
          maj = 1'b1;
          mnr = (((mj / 2) + i * mn) / mj) != (((mj / 2) + (i - 1) * mn) / mj);
        end
      end
      dn = (c == base + mj * int'(STEP_DIV));
    end
    return xmaj ? {maj, mnr, dn} : {mnr, maj, dn};
  endfunction

  task automatic wait_ready();
    int k;
    k = 0;
    while (cmd_if.cmd_ready !== 1'b1 && k < 20) begin
      @(negedge clock);
      k++;
    end
    chk("ready_wait", 32'(cmd_if.cmd_ready), 32'(1));
  endtask

  task automatic run_move(input int dx, input int dy, input logic pen,
                          input bit home_acc, input bit home_mid);
    int ax, ay, mj, mn, base, last, new_x, new_y;
    bit xmaj;
    ax    = (dx < 0) ? -dx : dx;
    ay    = (dy < 0) ? -dy : dy;
    xmaj  = (ax >= ay);
    mj    = xmaj ? ax : ay;
    mn    = xmaj ? ay : ax;
    base  = 1 + ((pen !== exp_pen) ? int'(PEN_SETTLE) : 0);
    last  = (mj == 0) ? base + 1 : base + mj * int'(STEP_DIV);
    new_x = (home_acc ? 0 : exp_x) + dx;
    new_y = (home_acc ? 0 : exp_y) + dy;
    wait_ready();
    cmd_if.cmd_dx    = DELTA_W'(dx);
    cmd_if.cmd_dy    = DELTA_W'(dy);
    cmd_if.cmd_pen   = pen;
    cmd_if.cmd_valid = 1'b1;
    home             = home_acc;
    for (int c = 1; c <= last + 1; c++) begin
      @(negedge clock);
      if (c == 1) begin
        cmd_if.cmd_valid = 1'b0;
        home             = 1'b0;
        chk("pen_down", 32'(pen_down), 32'(pen));
        chk("dir_x", 32'(dir_x), 32'(dx < 0));
        chk("dir_y", 32'(dir_y), 32'(dy < 0));
      end
      if (home_mid && c == 2 && c < last) begin
        home             = 1'b1;
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_dx    = DELTA_W'(7);
        cmd_if.cmd_dy    = DELTA_W'(7);
        cmd_if.cmd_pen   = ~pen;
      end
      if (c == last) begin
        home             = 1'b0;
        cmd_if.cmd_valid = 1'b0;
      end
      if (c <= last) begin
        chk("pulses", 32'({cmd_if.cmd_ready, busy, step_x, step_y, done}),
            32'({2'b01, exp_pulses(c, base, mj, mn, xmaj)}));
      end else begin
        chk("cur_x", 32'(cur_x), 32'(new_x));
        chk("cur_y", 32'(cur_y), 32'(new_y));
        chk("idle", 32'({cmd_if.cmd_ready, busy, done}), 32'(3'b100));
      end
    end
    exp_x   = new_x;
    exp_y   = new_y;
    exp_pen = pen;
  endtask

  // Abort after n major steps, holding cmd_valid high for the whole move.
  task automatic run_abort(input int dx, input int dy, input int n);
    int ax, ay, mj, mn, cut, kmin, sx, sy, new_x, new_y;
    bit xmaj;
    ax    = (dx < 0) ? -dx : dx;
    ay    = (dy < 0) ? -dy : dy;
    xmaj  = (ax >= ay);
    mj    = xmaj ? ax : ay;
    mn    = xmaj ? ay : ax;
    cut   = 1 + n * int'(STEP_DIV);
    kmin  = ((mj / 2) + n * mn) / mj;
    sx    = xmaj ? n : kmin;
    sy    = xmaj ? kmin : n;
    new_x = exp_x + ((dx < 0) ? -sx : sx);
    new_y = exp_y + ((dy < 0) ? -sy : sy);
    wait_ready();
    cmd_if.cmd_dx    = DELTA_W'(dx);
    cmd_if.cmd_dy    = DELTA_W'(dy);
    cmd_if.cmd_pen   = exp_pen;
    cmd_if.cmd_valid = 1'b1;
    for (int c = 1; c <= cut; c++) begin
      @(negedge clock);
      chk("abort_pulses", 32'({cmd_if.cmd_ready, busy, step_x, step_y, done}),
          32'({2'b01, exp_pulses(c, 1, mj, mn, xmaj)}));
      if (c == cut) abort = 1'b1;
    end
    @(negedge clock);
    abort            = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    chk("abort_idle", 32'({cmd_if.cmd_ready, busy, done}), 32'(3'b100));
    chk("abort_cur_x", 32'(cur_x), 32'(new_x));
    chk("abort_cur_y", 32'(cur_y), 32'(new_y));
    chk("abort_pen", 32'(pen_down), 32'(exp_pen));
    repeat (6) begin
      @(negedge clock);
      chk("abort_quiet", 32'({step_x, step_y, done, busy}), 32'(0));
    end
    chk("abort_hold_x", 32'(cur_x), 32'(new_x));
    exp_x = new_x;
    exp_y = new_y;
  endtask

  initial begin
    int   rdx;
    int   rdy;
    logic rpen;
    n_cmp            = 0;
    n_bad            = 0;
    exp_x            = 0;
    exp_y            = 0;
    exp_pen          = 1'b0;
    reset            = 1'b1;
    home             = 1'b0;
    abort            = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_dx    = '0;
    cmd_if.cmd_dy    = '0;
    cmd_if.cmd_pen   = 1'b0;

    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("rst_outs", 32'({step_x, dir_x, step_y, dir_y, pen_down, busy, done}), 32'(0));
    chk("rst_ready", 32'(cmd_if.cmd_ready), 32'(1));
    chk("rst_cur_x", 32'(cur_x), 32'(0));
    chk("rst_cur_y", 32'(cur_y), 32'(0));

    run_move(3, 0, 1'b0, 1'b0, 1'b0);
    run_move(-4, 2, 1'b0, 1'b0, 1'b0);
    run_move(1, 1, 1'b1, 1'b0, 1'b0);
    run_move(0, 0, 1'b1, 1'b0, 1'b0);

    run_abort(5, 0, 2);
    home = 1'b1;
    @(negedge clock);
    home = 1'b0;
    chk("home_x", 32'(cur_x), 32'(0));
    chk("home_y", 32'(cur_y), 32'(0));
    exp_x = 0;
    exp_y = 0;

    run_move(3, 3, 1'b0, 1'b0, 1'b0);
    run_move(2, -1, 1'b0, 1'b1, 1'b0);
    run_move(-3, 5, 1'b1, 1'b0, 1'b1);
    run_move(0, -6, 1'b1, 1'b0, 1'b0);
    run_abort(-32768, 0, 3);
    run_abort(3, -7, 4);

    for (int r = 0; r < 10; r++) begin
      rdx  = int'($urandom_range(0, 12)) - 6;
      rdy  = int'($urandom_range(0, 12)) - 6;
      rpen = 1'($urandom_range(0, 1));
      run_move(rdx, rdy, rpen, 1'b0, (r % 3) == 0);
    end

    // Reset in the middle of a move
    wait_ready();
    cmd_if.cmd_dx    = DELTA_W'(6);
    cmd_if.cmd_dy    = DELTA_W'(2);
    cmd_if.cmd_pen   = ~exp_pen;
    cmd_if.cmd_valid = 1'b1;
    @(negedge clock);
    cmd_if.cmd_valid = 1'b0;
    repeat (16) @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("midrst_outs", 32'({step_x, dir_x, step_y, dir_y, pen_down, busy, done}), 32'(0));
    chk("midrst_ready", 32'(cmd_if.cmd_ready), 32'(1));
    chk("midrst_cur", 32'({cur_x, cur_y} != '0), 32'(0));
    exp_x   = 0;
    exp_y   = 0;
    exp_pen = 1'b0;
    run_move(2, 1, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
